hazard_stall_unit: RTL and testbench

Decode-stage hazard detector that produces the Stall input consumed by the control unit, plus a global Freeze for memory wait.
- Decodes the ID-stage instruction itself, so it has no dependency on control-unit outputs and creates no combinational loop.
- Tracks in-flight register writes in a 2-entry scoreboard shift register mirroring EX and MEM.
- Stalls on load-use hazards and on decode-resolved branches whose operands are not yet forwardable.

---
 rtl/hazard_stall_unit_if.sv | 24 ++
 rtl/hazard_stall_unit.sv | 165 ++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Decode-stage hazard bus: the ID instruction and memory-wait status flow in,
// the pipeline stall/freeze controls and the stall-cycle counter flow out.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      INS;
    logic             INS_valid;
    logic             mem_wait;
    logic             Stall;
    logic             Freeze;
    logic [CNT_W-1:0] StallCount;

    // Pipeline side: presents the ID instruction, consumes the stall controls.
    modport master (
        output INS, INS_valid, mem_wait,
        input  Stall, Freeze, StallCount
    );

    // Hazard unit side.
    modport slave (
        input  INS, INS_valid, mem_wait,
        output Stall, Freeze, StallCount
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detector. Decodes the ID instruction on its own (no
// dependency on control-unit outputs) and compares its sources against a
// two-entry scoreboard that mirrors the destinations held in EX and MEM.
// Stall inserts a bubble into EX; Freeze holds the whole pipeline.
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_unit_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       load;
    } sb_entry_t;

    typedef struct packed {
        logic       use_rs;
        logic       use_rt;
        logic       branch;
        logic [4:0] dest;
        logic       load;
    } decode_t;

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign op = bus.INS[31:26];
    assign rs = bus.INS[25:21];
    assign rt = bus.INS[20:16];
    assign rd = bus.INS[15:11];
    assign fn = bus.INS[5:0];

    decode_t          dec;
    sb_entry_t        ex_q;
    sb_entry_t        mem_q;
    logic             ex_match;
    logic             mem_match;
    logic             hazard;
    logic             stall;
    logic             freeze;
    logic [CNT_W-1:0] stall_count;

    // Classify the ID instruction: which register sources it reads, whether
    // it resolves a branch in decode, and which register it writes.
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a bit unassigned; otherwise synthesis infers a latch.
        dec = '0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h03: begin
                        dec.use_rt = 1'b1;
                        dec.dest   = rd;
                    end
                    6'h08: begin
                        dec.use_rs = 1'b1;
                        dec.branch = 1'b1;
                    end
                    6'h09: begin
                        dec.use_rs = 1'b1;
                        dec.branch = 1'b1;
                        dec.dest   = rd;
                    end
                    default: begin
                        dec.use_rs = 1'b1;
                        dec.use_rt = 1'b1;
                        dec.dest   = rd;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                dec.use_rs = 1'b1;
                dec.dest   = rt;
            end
            6'h0F: begin
                dec.dest = rt;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                dec.use_rs = 1'b1;
                dec.dest   = rt;
                dec.load   = 1'b1;
            end
            6'h28, 6'h29, 6'h2B: begin
                dec.use_rs = 1'b1;
                dec.use_rt = 1'b1;
            end
            6'h04, 6'h05: begin
                dec.use_rs = 1'b1;
                dec.use_rt = 1'b1;
                dec.branch = 1'b1;
            end
            6'h06, 6'h07: begin
                dec.use_rs = 1'b1;
                dec.branch = 1'b1;
            end
            6'h01: begin
                dec.use_rs = 1'b1;
                dec.branch = 1'b1;
                dec.dest   = rt[4] ? 5'd31 : 5'd0;
            end
            6'h03: begin
                dec.dest = 5'd31;
            end
            default: begin
                dec = '0;
            end
        endcase
    end

    // Compare ID sources with the in-flight destinations and form the
    // load-use and decode-branch hazards; $zero never creates a dependency.
    always_comb begin
        ex_match  = (dec.use_rs && rs != 5'd0 && rs == ex_q.dest) ||
                    (dec.use_rt && rt != 5'd0 && rt == ex_q.dest);
        mem_match = (dec.use_rs && rs != 5'd0 && rs == mem_q.dest) ||
                    (dec.use_rt && rt != 5'd0 && rt == mem_q.dest);
        hazard    = bus.INS_valid && (
                        (ex_q.valid && ex_q.load && ex_match) ||
                        (dec.branch && ex_q.valid && ex_match) ||
                        (dec.branch && mem_q.valid && mem_q.load && mem_match));
        stall     = !rst && (hazard || bus.mem_wait);
        freeze    = !rst && bus.mem_wait;
    end

    assign bus.Stall      = stall;
    assign bus.Freeze     = freeze;
    assign bus.StallCount = stall_count;

    // Advance the EX/MEM scoreboard with the pipeline: hold while frozen,
    // shift in a bubble while stalled, otherwise shift in the ID instruction.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every
        // register samples pre-edge values, matching real flip-flops.
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (!freeze) begin
            mem_q <= ex_q;
            if (stall) begin
                ex_q <= '0;
            end else begin
                ex_q.valid <= bus.INS_valid && (dec.dest != 5'd0);
                ex_q.dest  <= dec.dest;
                ex_q.load  <= dec.load;
            end
        end
    end

    // Saturating count of cycles spent stalled or frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && stall_count != {CNT_W{1'b1}}) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed test-plan scenarios followed by
// randomized instruction streams, all compared against a reference model
// that tracks in-flight writers as a short queue of {dest, is_load}.
module tb_hazard_stall_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int dest;
        bit load;
    } flight_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_unit #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int      n_checks = 0;
    int      n_pass   = 0;
    int      m_cnt    = 0;
    flight_t fl[$];
    logic    last_stall;
    logic    last_freeze;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Instruction encoders.
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        enc_r = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        enc_i = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Reference decode: list the registers read, the register written,
    // and whether this is a decode-resolved branch or a load.
    function automatic void ref_decode(input logic [31:0] w, output int s0, output int s1,
                                       output int dest, output bit br, output bit ld);
        int op;
        int rs;
        int rt;
        int rd;
        int fn;
        op = int'(w[31:26]);
        rs = int'(w[25:21]);
        rt = int'(w[20:16]);
        rd = int'(w[15:11]);
        fn = int'(w[5:0]);
        s0 = 0; s1 = 0; dest = 0; br = 0; ld = 0;
        if (op == 0) begin
            dest = (fn == 8) ? 0 : rd;
            if (fn inside {0, 2, 3}) s1 = rt;
            else if (fn inside {8, 9}) begin s0 = rs; br = 1; end
            else begin s0 = rs; s1 = rt; end
        end else if (op inside {[8:14]}) begin
            s0 = rs; dest = rt;
        end else if (op == 15) begin
            dest = rt;
        end else if (op inside {32, 33, 35, 36, 37}) begin
            s0 = rs; dest = rt; ld = 1;
        end else if (op inside {40, 41, 43}) begin
            s0 = rs; s1 = rt;
        end else if (op inside {4, 5}) begin
            s0 = rs; s1 = rt; br = 1;
        end else if (op inside {6, 7}) begin
            s0 = rs; br = 1;
        end else if (op == 1) begin
            s0 = rs; br = 1; dest = (rt >= 16) ? 31 : 0;
        end else if (op == 3) begin
            dest = 31;
        end
    endfunction

    // A source conflicts with the youngest writer if that writer is a load
    // (or if ID is a branch), and with the older writer only for branches
    // waiting on a load result.
    function automatic bit src_hazard(input int s, input bit br);
        if (s <= 0) return 1'b0;
        return (s == fl[0].dest && fl[0].load) ||
               (br && s == fl[0].dest) ||
               (br && s == fl[1].dest && fl[1].load);
    endfunction

    function automatic void model_clear();
        flight_t e;
        e.dest = 0;
        e.load = 0;
        fl = {e, e};
    endfunction

    // One clock cycle: drive at the falling edge, check the DUT against the
    // model shortly after, then advance the model by the coming rising edge.
    task automatic tick(input logic [31:0] ins, input logic v, input logic mw,
                        input logic r, input string tag);
        int      s0, s1, d;
        bit      br, ld, haz;
        logic    es, ef;
        flight_t e;
        @(negedge clk);
        rst           = r;
        bus.INS       = ins;
        bus.INS_valid = v;
        bus.mem_wait  = mw;
        #1;
        ref_decode(ins, s0, s1, d, br, ld);
        haz = src_hazard(s0, br) || src_hazard(s1, br);
        es  = !r && ((v && haz) || mw);
        ef  = !r && mw;
        check({tag, ".stall"}, 32'(bus.Stall), 32'(es));
        check({tag, ".freeze"}, 32'(bus.Freeze), 32'(ef));
        check({tag, ".count"}, 32'(bus.StallCount), 32'(m_cnt));
        last_stall  = bus.Stall;
        last_freeze = bus.Freeze;
        if (r) begin
            model_clear();
            m_cnt = 0;
        end else begin
            if (es && m_cnt < CNT_MAX) m_cnt++;
            if (!mw) begin
                e.dest = (es || !v) ? 0 : d;
                e.load = ld;
                fl.push_front(e);
                void'(fl.pop_back());
            end
        end
    endtask

    task automatic reset_dut();
        tick(32'h0, 1'b0, 1'b0, 1'b1, "rst");
        tick(32'h0, 1'b0, 1'b0, 1'b1, "rst");
    endtask

    function automatic logic [31:0] rand_ins();
        int ops[20] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12, 15, 32, 35, 37, 40, 43, 63};
        int fns[7]  = '{0, 2, 3, 8, 9, 32, 42};
        int regs[3];
        for (int i = 0; i < 3; i++) begin
            regs[i] = int'($urandom_range(0, 6));
            if (regs[i] == 6) regs[i] = 31;
        end
        rand_ins = {6'(ops[$urandom_range(0, 19)]), 5'(regs[0]), 5'(regs[1]),
                    5'(regs[2]), 5'($urandom_range(0, 31)), 6'(fns[$urandom_range(0, 6)])};
        if (rand_ins[31:26] == 6'h01 && $urandom_range(0, 1) == 1) rand_ins[20] = 1'b1;
    endfunction

    initial begin
        logic [31:0] lw8, add10, nop;
        rst           = 1'b1;
        bus.INS       = '0;
        bus.INS_valid = 1'b0;
        bus.mem_wait  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);

        nop   = 32'h0;
        lw8   = enc_i(35, 9, 8, 0);
        add10 = enc_r(8, 11, 10, 32);

        // Reset state.
        #1;
        check("reset.stall", 32'(bus.Stall), 32'd0);
        check("reset.count", 32'(bus.StallCount), 32'd0);

        // 1: load-use stalls exactly one cycle.
        reset_dut();
        tick(lw8, 1, 0, 0, "tp1.lw");
        tick(add10, 1, 0, 0, "tp1.add");
        check("tp1.stall1", 32'(last_stall), 32'd1);
        tick(add10, 1, 0, 0, "tp1.add2");
        check("tp1.stall2", 32'(last_stall), 32'd0);
        tick(nop, 1, 0, 0, "tp1.nop");
        check("tp1.count", 32'(bus.StallCount), 32'd1);

        // 2: branch right after a load stalls two cycles.
        reset_dut();
        tick(enc_i(35, 5, 4, 0), 1, 0, 0, "tp2.lw");
        tick(enc_i(4, 4, 0, 4), 1, 0, 0, "tp2.beq1");
        check("tp2.stall1", 32'(last_stall), 32'd1);
        tick(enc_i(4, 4, 0, 4), 1, 0, 0, "tp2.beq2");
        check("tp2.stall2", 32'(last_stall), 32'd1);
        tick(enc_i(4, 4, 0, 4), 1, 0, 0, "tp2.beq3");
        check("tp2.stall3", 32'(last_stall), 32'd0);
        tick(nop, 1, 0, 0, "tp2.nop");
        check("tp2.count", 32'(bus.StallCount), 32'd2);

        // 3: branch after ALU producer; then with an independent gap.
        reset_dut();
        tick(enc_i(8, 3, 3, 16'hFFFF), 1, 0, 0, "tp3.addi");
        tick(enc_i(5, 3, 0, 4), 1, 0, 0, "tp3.bne1");
        check("tp3.stall1", 32'(last_stall), 32'd1);
        tick(enc_i(5, 3, 0, 4), 1, 0, 0, "tp3.bne2");
        check("tp3.stall2", 32'(last_stall), 32'd0);
        reset_dut();
        tick(enc_i(8, 3, 3, 16'hFFFF), 1, 0, 0, "tp3.addi_g");
        tick(enc_r(21, 22, 20, 32), 1, 0, 0, "tp3.gap");
        tick(enc_i(5, 3, 0, 4), 1, 0, 0, "tp3.bne_g");
        check("tp3.gap_stall", 32'(last_stall), 32'd0);

        // 4: $zero and instructions that read nothing.
        reset_dut();
        tick(enc_i(35, 1, 0, 0), 1, 0, 0, "tp4.lw0");
        tick(enc_r(0, 0, 2, 32), 1, 0, 0, "tp4.add0");
        check("tp4.zero", 32'(last_stall), 32'd0);
        tick(lw8, 1, 0, 0, "tp4.lw8a");
        tick(enc_i(15, 0, 8, 5), 1, 0, 0, "tp4.lui");
        check("tp4.lui", 32'(last_stall), 32'd0);
        tick(lw8, 1, 0, 0, "tp4.lw8b");
        tick({6'h02, 26'h40}, 1, 0, 0, "tp4.j");
        check("tp4.j", 32'(last_stall), 32'd0);

        // 5: memory wait while a load-use hazard is pending.
        reset_dut();
        tick(lw8, 1, 0, 0, "tp5.lw");
        for (int i = 0; i < 3; i++) begin
            tick(add10, 1, 1, 0, "tp5.wait");
            check("tp5.wait_stall", 32'(last_stall), 32'd1);
            check("tp5.wait_freeze", 32'(last_freeze), 32'd1);
        end
        tick(add10, 1, 0, 0, "tp5.unfreeze");
        check("tp5.lu_stall", 32'(last_stall), 32'd1);
        check("tp5.lu_freeze", 32'(last_freeze), 32'd0);
        tick(add10, 1, 0, 0, "tp5.go");
        check("tp5.go_stall", 32'(last_stall), 32'd0);
        tick(nop, 1, 0, 0, "tp5.nop");
        check("tp5.count", 32'(bus.StallCount), 32'd4);

        // 6: reset in the middle of a stall, then counter saturation.
        reset_dut();
        tick(lw8, 1, 0, 0, "tp6.lw");
        tick(add10, 1, 0, 0, "tp6.add");
        check("tp6.pre", 32'(last_stall), 32'd1);
        tick(add10, 1, 0, 1, "tp6.rst");
        check("tp6.rst_stall", 32'(last_stall), 32'd0);
        tick(add10, 1, 0, 0, "tp6.after");
        check("tp6.after_stall", 32'(last_stall), 32'd0);
        check("tp6.after_count", 32'(bus.StallCount), 32'd0);
        for (int i = 0; i < 20; i++) tick(nop, 1, 1, 0, "tp6.sat");
        tick(nop, 1, 0, 0, "tp6.nop");
        check("tp6.sat_count", 32'(bus.StallCount), 32'(CNT_MAX));

        // Randomized streams against the model.
        reset_dut();
        for (int i = 0; i < 800; i++) begin
            tick(rand_ins(), $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 59) == 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
